// File: rtl/user_rom_arbiter.sv
// Two-manager round-robin arbiter in front of a single ROM subordinate.
// Grants are issued combinationally; a small route FIFO remembers which
// manager owns each in-flight transaction so responses return in order.
module user_rom_arbiter #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned IdWidth    = 1,
  parameter int unsigned RouteDepth = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               m0_req_i,
  input  logic [AddrWidth-1:0]               m0_addr_i,
  input  logic                               m0_we_i,
  input  logic [IdWidth-1:0]                 m0_aid_i,
  output logic                               m0_gnt_o,
  output logic                               m0_rvalid_o,
  output logic [DataWidth-1:0]               m0_rdata_o,
  output logic [IdWidth-1:0]                 m0_rid_o,
  output logic                               m0_err_o,
  input  logic                               m1_req_i,
  input  logic [AddrWidth-1:0]               m1_addr_i,
  input  logic                               m1_we_i,
  input  logic [IdWidth-1:0]                 m1_aid_i,
  output logic                               m1_gnt_o,
  output logic                               m1_rvalid_o,
  output logic [DataWidth-1:0]               m1_rdata_o,
  output logic [IdWidth-1:0]                 m1_rid_o,
  output logic                               m1_err_o,
  output logic                               s_req_o,
  output logic [AddrWidth-1:0]               s_addr_o,
  output logic                               s_we_o,
  output logic [IdWidth-1:0]                 s_aid_o,
  input  logic                               s_gnt_i,
  input  logic                               s_rvalid_i,
  input  logic [DataWidth-1:0]               s_rdata_i,
  input  logic [IdWidth-1:0]                 s_rid_i,
  input  logic                               s_err_i,
  output logic [$clog2(RouteDepth+1)-1:0]    outstanding_o,
  output logic                               unexp_rsp_o
);

  localparam int unsigned PtrWidth = $clog2(RouteDepth);
  localparam int unsigned CntWidth = $clog2(RouteDepth + 1);

  logic [RouteDepth-1:0] route_q;
  logic [PtrWidth-1:0]   wr_ptr_q;
  logic [PtrWidth-1:0]   rd_ptr_q;
  logic [CntWidth-1:0]   count_q;
  logic                  rr_q;
  logic                  unexp_q;

  logic sel;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

  // Pick the requesting manager; on contention the round-robin pointer decides.
  always_comb begin
    sel = 1'b0;
    if (m0_req_i && m1_req_i) begin
      sel = rr_q;
    end else if (m1_req_i) begin
      sel = 1'b1;
    end
  end

  assign full  = (count_q == CntWidth'(RouteDepth));
  assign empty = (count_q == '0);
  assign head  = route_q[rd_ptr_q];

  assign s_req_o  = (m0_req_i | m1_req_i) & ~full;
  assign s_addr_o = sel ? m1_addr_i : m0_addr_i;
  assign s_we_o   = sel ? m1_we_i   : m0_we_i;
  assign s_aid_o  = sel ? m1_aid_i  : m0_aid_i;

  assign push     = s_req_o & s_gnt_i;
  assign pop      = s_rvalid_i & ~empty;
  assign m0_gnt_o = push & ~sel;
  assign m1_gnt_o = push & sel;

  // Steer the subordinate response to the manager at the FIFO head.
  always_comb begin
    m0_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m0_rid_o    = '0;
    m0_err_o    = 1'b0;
    m1_rvalid_o = 1'b0;
    m1_rdata_o  = '0;
    m1_rid_o    = '0;
    m1_err_o    = 1'b0;
    if (pop) begin
      if (head) begin
        m1_rvalid_o = 1'b1;
        m1_rdata_o  = s_rdata_i;
        m1_rid_o    = s_rid_i;
        m1_err_o    = s_err_i;
      end else begin
        m0_rvalid_o = 1'b1;
        m0_rdata_o  = s_rdata_i;
        m0_rid_o    = s_rid_i;
        m0_err_o    = s_err_i;
      end
    end
  end

  // Route FIFO, occupancy count and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      route_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      if (push) begin
        route_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= wr_ptr_q + PtrWidth'(1);
        rr_q              <= ~sel;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for responses arriving with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      unexp_q <= 1'b0;
    end else if (s_rvalid_i && empty) begin
      unexp_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign unexp_rsp_o   = unexp_q;

endmodule

// File: doc/user_rom_arbiter.md
USER_ROM_ARBITER -- requirements
Module: user_rom_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, request address width.
REQ-002 SHALL have parameter DataWidth, default 32, read/write data width.
REQ-003 SHALL have parameter IdWidth, default 1, transaction ID width.
REQ-004 SHALL have parameter RouteDepth, default 4, maximum outstanding transactions (power of two, >=2).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i  input  1  clock (all logic on rising edge).
REQ-006 SHALL have rst_i  input  1  asynchronous active-high reset.
REQ-007 SHALL have, for N=0,1: mN_req_i  input  1  manager N request valid.
REQ-008 SHALL have mN_addr_i  input  AddrWidth  manager N byte address.
REQ-009 SHALL have mN_we_i  input  1  manager N write enable.
REQ-010 SHALL have mN_aid_i  input  IdWidth  manager N request ID.
REQ-011 SHALL have mN_gnt_o  output  1  manager N grant.
REQ-012 SHALL have mN_rvalid_o  output  1  manager N response valid.
REQ-013 SHALL have mN_rdata_o  output  DataWidth  manager N read data.
REQ-014 SHALL have mN_rid_o  output  IdWidth  manager N response ID.
REQ-015 SHALL have mN_err_o  output  1  manager N response error.
REQ-016 SHALL have s_req_o / s_addr_o / s_we_o / s_aid_o  output  1/AddrWidth/1/IdWidth  subordinate (ROM) request.
REQ-017 SHALL have s_gnt_i  input  1  subordinate grant.
REQ-018 SHALL have s_rvalid_i / s_rdata_i / s_rid_i / s_err_i  input  1/DataWidth/IdWidth/1  subordinate response.
REQ-019 SHALL have outstanding_o  output  $clog2(RouteDepth+1)  in-flight transaction count.
REQ-020 SHALL have unexp_rsp_o  output  1  sticky flag: response received with no outstanding transaction.

Function
REQ-021 SHALL select sel combinationally: only one mN_req_i high -> that N; both high -> manager indicated by rr_q; none -> s_req_o=0.
REQ-022 SHALL drive s_req_o = (m0_req_i|m1_req_i) & ~full; s_addr_o/s_we_o/s_aid_o = selected manager fields (manager 0 fields when idle).
REQ-023 SHALL drive mN_gnt_o = s_req_o & s_gnt_i & (sel==N); at most one grant per cycle; zero-cycle grant path.
REQ-024 SHALL, on each granted handshake, push sel into a RouteDepth-entry route FIFO and set rr_q to the non-selected manager (1-sel).
REQ-025 SHALL hold rr_q when no handshake occurs; requests blocked by s_gnt_i=0 keep their arbitration position.
REQ-026 SHALL define full = (count == RouteDepth); when full, no grant even if a pop occurs the same cycle.
REQ-027 SHALL, on s_rvalid_i with FIFO non-empty, pop head H and drive mH_rvalid_o=1, mH_rdata_o=s_rdata_i, mH_rid_o=s_rid_i, mH_err_o=s_err_i, same cycle (combinational).
REQ-028 SHALL drive the non-routed manager's rvalid/rdata/rid/err to 0 every cycle.
REQ-029 SHALL, on s_rvalid_i with FIFO empty, drop the response (no mN_rvalid_o) and set unexp_rsp_o=1 until reset.
REQ-030 SHALL support simultaneous push and pop: count unchanged, FIFO order preserved; pointers wrap modulo RouteDepth.
REQ-031 SHALL output outstanding_o = count, registered, updated +1 on push only, -1 on pop only.
REQ-032 SHALL NOT inspect mN_we_i; write errors are produced by the subordinate and forwarded unchanged.

Reset
REQ-033 SHALL, while rst_i=1, clear FIFO pointers, count, rr_q (prefer manager 0), unexp_rsp_o.
REQ-034 SHALL output during reset: all grants 0 unless combinational request path is active (s_req_o follows REQ-022 with full=0), all rvalid 0, outstanding_o=0.
REQ-035 SHALL discard in-flight routing on reset mid-operation; later responses count as unexpected.

Verification
REQ-036 Single manager: m0 reads 0x0, 0x4 back-to-back, s_gnt_i=1, ROM 2-cycle latency -> m0_rvalid_o at cycles 2,3 with 0x656D7544, 0x4326696E; m1_rvalid_o=0.
REQ-037 Contention: m0,m1 both request every cycle from reset -> grants alternate m0,m1,m0,m1; responses routed in the same order.
REQ-038 Full: s_rvalid_i held 0, 4 grants -> outstanding_o=4, grants stop; one response -> outstanding_o=3 next cycle, grant resumes cycle after.
REQ-039 Push+pop same cycle at count=2 -> outstanding_o stays 2, responses delivered in issue order.
REQ-040 Write: m1 write to 0x8 -> m1_err_o=1 with m1_rid_o=m1_aid_i, rdata 0; then s_rvalid_i with empty FIFO -> unexp_rsp_o=1, no mN_rvalid_o.
REQ-041 Reset asserted with 2 outstanding -> outstanding_o=0, rr_q=m0 immediately; post-reset both requesting -> m0 granted first.
